// File: rtl/pixel_writeback.sv
// pixel_writeback: buffers worker pixel results in a small FIFO and drains them
// as byte-lane-masked word writes on a memory master port. It counts completed
// writes and pulses frame_done once per FRAME_PIXELS completions.
//
// Handshakes:
//   worker side - a result is transferred on a rising clk edge when found=1
//                 and the FIFO is not full (take=1); worker_clear echoes
//                 sel_onehot in that same cycle so the worker drops its flag.
//   memory side - a write is offered while m_write=1; it is transferred on a
//                 rising clk edge where m_waitrequest=0. Until then address,
//                 data and byte enables stay frozen.
module pixel_writeback #(
    parameter int NUM_BITS     = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                found,
    input  logic [NUM_BITS-1:0] sel_onehot,
    input  logic [7:0]          sel_data,
    input  logic [31:0]         sel_address,
    output logic [NUM_BITS-1:0] worker_clear,
    output logic                m_write,
    output logic [31:0]         m_address,
    output logic [31:0]         m_writedata,
    output logic [3:0]          m_byteenable,
    input  logic                m_waitrequest,
    output logic [31:0]         pixel_count,
    output logic                frame_done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   OCC_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   OCC_FULL   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]      FRAME_LAST = 32'(FRAME_PIXELS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    // Each entry is {byte address, pixel byte}.
    logic [39:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occupancy;
    logic             fifo_full;
    logic             fifo_empty;
    logic             take;
    logic             pop;
    logic             complete;
    logic [39:0]      head;

    assign fifo_full  = (occupancy == OCC_FULL);
    assign fifo_empty = (occupancy == '0);
    // found is gated by n_rst so nothing is acknowledged while in reset.
    assign take         = found & n_rst & ~fifo_full;
    assign worker_clear = take ? sel_onehot : '0;
    assign head         = fifo_mem[rd_ptr];

    // Pixel storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (take) begin
            fifo_mem[wr_ptr] <= {sel_address, sel_data};
        end
    end

    // FIFO pointers and exact occupancy; push+pop together leaves it unchanged.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (take) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({take, pop})
                2'b10:   occupancy <= occupancy + OCC_ONE;
                2'b01:   occupancy <= occupancy - OCC_ONE;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Write-port FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: pop whenever the output stage is free or just completed.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = WRITE;
                end
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    complete = 1'b1;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output stage: load the popped pixel as an aligned word write, hold under stall.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            m_byteenable <= '0;
        end else if (pop) begin
            m_write      <= 1'b1;
            m_address    <= {head[39:10], 2'b00};
            m_writedata  <= {4{head[7:0]}};
            m_byteenable <= 4'b0001 << head[9:8];
        end else if (complete) begin
            m_write <= 1'b0;
        end
    end

    // Completion counter with frame wrap and a one-cycle frame_done pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pixel_count <= '0;
            frame_done  <= 1'b0;
        end else if (complete) begin
            if (pixel_count == FRAME_LAST) begin
                pixel_count <= '0;
                frame_done  <= 1'b1;
            end else begin
                pixel_count <= pixel_count + 32'd1;
                frame_done  <= 1'b0;
            end
        end else begin
            frame_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_writeback.sv
// Bench for pixel_writeback: directed pixel vectors with hand-computed word
// writes; a negedge monitor pops the expected queue on every completed write.
module tb_pixel_writeback;

    localparam int FRAME = 3;

    logic        clk;
    logic        n_rst;
    logic        found;
    logic [7:0]  sel_onehot;
    logic [7:0]  sel_data;
    logic [31:0] sel_address;
    logic [7:0]  worker_clear;
    logic        m_write;
    logic [31:0] m_address;
    logic [31:0] m_writedata;
    logic [3:0]  m_byteenable;
    logic        m_waitrequest;
    logic [31:0] pixel_count;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int fd_seen  = 0;

    // Expected write: {address, writedata, byteenable}.
    logic [67:0] exp_q[$];
    logic [31:0] exp_cnt     = 0;
    logic        exp_fd      = 0;
    bit          cnt_pending = 0;

    // Directed vectors and their hand-computed writes.
    logic [7:0]  v_oh   [9];
    logic [31:0] v_addr [9];
    logic [7:0]  v_data [9];
    logic [31:0] e_addr [9];
    logic [31:0] e_data [9];
    logic [3:0]  e_be   [9];

    pixel_writeback #(
        .NUM_BITS    (8),
        .FIFO_DEPTH  (4),
        .FRAME_PIXELS(FRAME)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .found        (found),
        .sel_onehot   (sel_onehot),
        .sel_data     (sel_data),
        .sel_address  (sel_address),
        .worker_clear (worker_clear),
        .m_write      (m_write),
        .m_address    (m_address),
        .m_writedata  (m_writedata),
        .m_byteenable (m_byteenable),
        .m_waitrequest(m_waitrequest),
        .pixel_count  (pixel_count),
        .frame_done   (frame_done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer vector v for one cycle; called just after a rising edge.
    task automatic issue(input int v, input bit exp_acc);
        found       = 1'b1;
        sel_onehot  = v_oh[v];
        sel_address = v_addr[v];
        sel_data    = v_data[v];
        #1;
        check("worker_clear", 68'(worker_clear), exp_acc ? 68'(v_oh[v]) : 68'd0);
        if (exp_acc) begin
            exp_q.push_back({e_addr[v], e_data[v], e_be[v]});
        end
        @(posedge clk);
        #1;
        found = 1'b0;
    endtask

    // Wait (bounded) until every expected write has completed.
    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (exp_q.size() == 0 && !m_write) break;
            @(negedge clk);
        end
        check("drain_queue", 68'(exp_q.size()), 68'd0);
        check("drain_idle", 68'(m_write), 68'd0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!n_rst) begin
            cnt_pending = 0;
        end else begin
            if (cnt_pending) begin
                check("pixel_count", 68'(pixel_count), 68'(exp_cnt));
                check("frame_done", 68'(frame_done), 68'(exp_fd));
                if (frame_done) fd_seen++;
                cnt_pending = 0;
            end else begin
                check("frame_done_quiet", 68'(frame_done), 68'd0);
            end
            if (m_write && !m_waitrequest) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 68'(m_address), 68'hDEAD_0000);
                end else begin
                    logic [67:0] e;
                    e = exp_q.pop_front();
                    check("m_address", 68'(m_address), 68'(e[67:36]));
                    check("m_writedata", 68'(m_writedata), 68'(e[35:4]));
                    check("m_byteenable", 68'(m_byteenable), 68'(e[3:0]));
                end
                if (exp_cnt == 32'(FRAME - 1)) begin
                    exp_cnt = 0;
                    exp_fd  = 1'b1;
                end else begin
                    exp_cnt = exp_cnt + 1;
                    exp_fd  = 1'b0;
                end
                cnt_pending = 1;
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Directed stimulus
    initial begin
        v_oh   = '{8'h04, 8'h01, 8'h02, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
        v_addr = '{32'h0000_1003, 32'h0000_2000, 32'h0000_2001, 32'h0000_2002, 32'h0000_2007,
                   32'hFFFF_FFFE, 32'h1234_5679, 32'h8000_0000, 32'h0000_0003};
        v_data = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3, 8'h7E, 8'h99};
        e_addr = '{32'h0000_1000, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000, 32'h0000_2004,
                   32'hFFFF_FFFC, 32'h1234_5678, 32'h8000_0000, 32'h0000_0000};
        e_data = '{32'hA5A5_A5A5, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444,
                   32'h5A5A_5A5A, 32'hC3C3_C3C3, 32'h7E7E_7E7E, 32'h9999_9999};
        e_be   = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0100, 4'b0010, 4'b0001, 4'b1000};

        // Reset state, with found asserted to show it is ignored.
        n_rst         = 1'b0;
        found         = 1'b1;
        sel_onehot    = 8'hFF;
        sel_data      = 8'h00;
        sel_address   = 32'h0;
        m_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_worker_clear", 68'(worker_clear), 68'd0);
        check("rst_m_write", 68'(m_write), 68'd0);
        check("rst_m_address", 68'(m_address), 68'd0);
        check("rst_m_writedata", 68'(m_writedata), 68'd0);
        check("rst_m_byteenable", 68'(m_byteenable), 68'd0);
        check("rst_pixel_count", 68'(pixel_count), 68'd0);
        check("rst_frame_done", 68'(frame_done), 68'd0);
        found = 1'b0;
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;

        // Single pixel and one-cycle latency.
        issue(0, 1'b1);
        @(negedge clk);
        check("latency_e0", 68'(m_write), 68'd0);
        @(negedge clk);
        check("latency_e1", 68'(m_write), 68'd1);
        drain();

        // Stall: outputs held for 5 cycles, count unchanged.
        @(posedge clk);
        #1;
        m_waitrequest = 1'b1;
        issue(1, 1'b1);
        for (int w = 0; w < 5 && !m_write; w++) @(negedge clk);
        check("stall_start", 68'(m_write), 68'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_m_write", 68'(m_write), 68'd1);
            check("stall_m_address", 68'(m_address), 68'(e_addr[1]));
            check("stall_m_writedata", 68'(m_writedata), 68'(e_data[1]));
            check("stall_m_byteenable", 68'(m_byteenable), 68'(e_be[1]));
            check("stall_pixel_count", 68'(pixel_count), 68'd1);
        end

        // Full: write stalled, 6 offers -> 4 accepted, 2 refused.
        @(posedge clk);
        #1;
        issue(2, 1'b1);
        issue(3, 1'b1);
        issue(4, 1'b1);
        issue(5, 1'b1);
        issue(6, 1'b0);
        issue(7, 1'b0);
        check("full_hold_address", 68'(m_address), 68'(e_addr[1]));
        m_waitrequest = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("b2b_m_write", 68'(m_write), 68'd1);
        end
        @(negedge clk);
        check("b2b_end", 68'(m_write), 68'd0);
        drain();

        // Simultaneous push/pop at occupancy 1, twice; order 8, 0, 6.
        @(posedge clk);
        #1;
        m_waitrequest = 1'b1;
        issue(8, 1'b1);
        issue(0, 1'b1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        m_waitrequest = 1'b0;
        issue(6, 1'b1);
        drain();

        // Reset mid-write with two entries buffered.
        @(posedge clk);
        #1;
        m_waitrequest = 1'b1;
        issue(2, 1'b1);
        issue(3, 1'b1);
        issue(4, 1'b1);
        @(negedge clk);
        check("pre_rst_m_write", 68'(m_write), 68'd1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_m_write", 68'(m_write), 68'd0);
        check("async_rst_m_address", 68'(m_address), 68'd0);
        check("async_rst_pixel_count", 68'(pixel_count), 68'd0);
        exp_q.delete();
        exp_cnt = 0;
        exp_fd  = 1'b0;
        @(posedge clk);
        #1;
        n_rst         = 1'b1;
        m_waitrequest = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("post_rst_no_write", 68'(m_write), 68'd0);
        end
        @(posedge clk);
        #1;
        issue(7, 1'b1);
        drain();
        @(negedge clk);

        // Nine completions before reset at FRAME=3 -> three pulses; one after.
        check("frame_pulses", 68'(fd_seen), 68'd3);
        check("final_pixel_count", 68'(pixel_count), 68'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pixel_writeback.md
PIXEL_WRITEBACK -- requirements
Module: pixel_writeback

Interface
REQ-001 The module SHALL have parameter NUM_BITS, default 8, meaning the number of worker blocks (the width of the one-hot select).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, meaning the number of pixel buffer entries (a power of two, at least 2).
REQ-003 The module SHALL have parameter FRAME_PIXELS, default 307200, meaning the number of completed writes per frame.
REQ-004 The module SHALL have one clock and an asynchronous active-low reset: clk is a 1-bit input, the single clock, rising edge; n_rst is a 1-bit input, asynchronous active-low reset.
REQ-005 found, input, 1 bit: a worker result is presented this cycle.
REQ-006 sel_onehot, input, NUM_BITS bits: one-hot index of the presented worker.
REQ-007 sel_data, input, 8 bits: the pixel value.
REQ-008 sel_address, input, 32 bits: the pixel byte address.
REQ-009 worker_clear, output, NUM_BITS bits: clears the done flag of the accepted worker.
REQ-010 m_write, output, 1 bit: write request on the memory master port.
REQ-011 m_address, output, 32 bits: word-aligned write address.
REQ-012 m_writedata, output, 32 bits: write data.
REQ-013 m_byteenable, output, 4 bits: byte lane enables.
REQ-014 m_waitrequest, input, 1 bit: the slave stalls the current write.
REQ-015 pixel_count, output, 32 bits: writes completed in the current frame.
REQ-016 frame_done, output, 1 bit: one-cycle pulse when a frame completes.

Function
REQ-017 take SHALL equal found AND NOT fifo_full, evaluated combinationally.
REQ-018 worker_clear SHALL equal sel_onehot when take is 1 and all-zero otherwise, and SHALL be combinational with no register stage.
REQ-019 On a clk edge with take=1, the FIFO SHALL store {sel_address, sel_data} at the write pointer and increment the write pointer modulo FIFO_DEPTH.
REQ-020 When the FIFO is full, found SHALL be refused (take=0, worker_clear=0) even if a pop occurs in the same cycle.
REQ-021 Occupancy SHALL be tracked so that full and empty are exact; a simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 The FSM SHALL have exactly two states, IDLE and WRITE.
REQ-023 In IDLE with the FIFO non-empty, the FSM SHALL pop the head at the next edge, load the output registers, set m_write=1 and go to WRITE.
REQ-024 In IDLE with the FIFO empty, the FSM SHALL remain in IDLE with m_write=0.
REQ-025 The minimum latency from an accepting edge E0 (empty FIFO, IDLE) to m_write=1 SHALL be one cycle: m_write is high after E1.
REQ-026 m_address SHALL be loaded as {addr[31:2], 2'b00}.
REQ-027 m_byteenable SHALL be loaded as 4'b0001 shifted left by addr[1:0].
REQ-028 m_writedata SHALL be loaded as the pixel byte replicated to all four lanes.
REQ-029 In WRITE, while m_waitrequest=1, m_write, m_address, m_writedata and m_byteenable SHALL be held stable.
REQ-030 In WRITE, an edge with m_waitrequest=0 SHALL complete the transaction; if the FIFO is non-empty the head SHALL be popped and loaded with m_write kept at 1 (back-to-back), otherwise m_write SHALL go to 0 and the FSM SHALL return to IDLE.
REQ-031 Each completion SHALL increment pixel_count by 1.
REQ-032 The completion that makes pixel_count reach FRAME_PIXELS SHALL instead set pixel_count to 0 and pulse frame_done for exactly one cycle.
REQ-033 A push into a FIFO holding exactly one entry in the same cycle as that entry is popped SHALL be accepted, and order SHALL be preserved (FIFO order equals acceptance order).

Reset
REQ-034 While n_rst=0, asynchronously: FSM=IDLE; FIFO pointers and occupancy=0; m_write=0; m_address=0; m_writedata=0; m_byteenable=0; pixel_count=0; frame_done=0.
REQ-035 Reset asserted mid-transaction or with a non-empty FIFO SHALL abandon all buffered entries, with no write issued after release until a new acceptance occurs.
REQ-036 worker_clear SHALL be 0 during reset because fifo_full is forced 0 and found is gated by n_rst.

Verification
REQ-037 Single pixel: found=1, sel_onehot=8'h04, sel_address=32'h0000_1003, sel_data=8'hA5, waitrequest=0 -> worker_clear=8'h04 that cycle; one cycle later m_write=1, m_address=32'h0000_1000, m_byteenable=4'b1000, m_writedata=32'hA5A5A5A5; pixel_count=1.
REQ-038 Stall: m_waitrequest=1 for 5 cycles during a write -> outputs held constant for all 5 cycles; the count increments only after waitrequest drops.
REQ-039 Full: waitrequest=1 with found=1 for 6 cycles -> 4 accepts, then worker_clear=0 and no FIFO overwrite; after release, the 4 writes occur in order, back-to-back.
REQ-040 Frame wrap (FRAME_PIXELS=3): 3 completions -> frame_done high for one cycle on the third completion, and pixel_count=0.
REQ-041 Reset mid-WRITE with 2 entries buffered -> m_write=0 immediately; after release, no write occurs without a new found.
REQ-042 Simultaneous push/pop with occupancy 1 -> occupancy stays 1 and the next write carries the newly pushed pixel.
